// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer driving the PC strobes, the memory req/ack port and the decode valid/ready port.
// Optional macro FETCH_TIMEOUT_EN adds the TIMEOUT parameter, a WAIT/DRAIN abort and a sticky fetch_err output.
module fetch_ctrl #(
  parameter int AW = 8,
  parameter int IW = 16
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 15
`endif
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] pcout,
  output logic [AW-1:0] pcin,
  output logic          incr,
  output logic          load,
  output logic [AW-1:0] mem_addr,
  output logic          mem_req,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_rdata,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          branch_valid,
  input  logic [AW-1:0] branch_target
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic          fetch_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_mem_req;
  logic [AW-1:0]   r_mem_addr;
  logic [IW-1:0]   r_instr;
  logic            r_instr_valid;
  logic            w_req_next;
  logic            w_valid_next;
  logic            w_issue;
  logic            w_capture;
  logic            w_incr;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CW-1:0]   r_to_cnt;
  logic            r_fetch_err;
  logic            w_to_hit;
  logic            w_to_abort;
  logic            w_waiting;

  assign w_waiting = (r_state == S_WAIT) || (r_state == S_DRAIN);
  assign w_to_hit  = (r_to_cnt == CW'(TIMEOUT - 1));
`endif

  always_comb begin
    w_next_state = r_state;
    w_req_next   = r_mem_req;
    w_valid_next = r_instr_valid;
    w_issue      = 1'b0;
    w_capture    = 1'b0;
    w_incr       = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    w_to_abort   = 1'b0;
`endif
    case (r_state)
      S_IDLE: w_next_state = S_ISSUE;
      S_ISSUE: begin
        // A redirect in this cycle means pcout is stale; re-issue next cycle.
        if (!branch_valid) begin
          w_issue      = 1'b1;
          w_req_next   = 1'b1;
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          w_req_next   = 1'b0;
          w_next_state = S_ISSUE;
          if (!branch_valid) begin
            w_capture    = 1'b1;
            w_valid_next = 1'b1;
            w_incr       = 1'b1;
            w_next_state = S_HOLD;
          end
        end else if (branch_valid) begin
          w_next_state = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (branch_valid || instr_ready) begin
          w_valid_next = 1'b0;
          w_next_state = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (mem_ack) begin
          w_req_next   = 1'b0;
          w_next_state = S_ISSUE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
`ifdef FETCH_TIMEOUT_EN
    if (w_waiting && !mem_ack && w_to_hit) begin
      w_to_abort   = 1'b1;
      w_req_next   = 1'b0;
      w_next_state = S_ISSUE;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      r_mem_req     <= w_req_next;
      r_instr_valid <= w_valid_next;
      if (w_issue)   r_mem_addr <= pcout;
      if (w_capture) r_instr    <= mem_rdata;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Counter restarts on every entry into WAIT or DRAIN, including WAIT->DRAIN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_to_cnt    <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      if (w_next_state != r_state) r_to_cnt <= '0;
      else if (w_waiting)          r_to_cnt <= r_to_cnt + CW'(1);
      if (w_to_abort) r_fetch_err <= 1'b1;
    end
  end

  assign fetch_err = r_fetch_err;
`endif

  assign pcin        = branch_target;
  assign load        = reset & branch_valid;
  assign incr        = reset & w_incr;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized checks of fetch_ctrl against a transaction-level fetch model and a bench-side PC.
module tb_fetch_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  pc = 8'h03;
  logic [7:0]  pcin;
  logic        incr, load;
  logic [7:0]  mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch_valid = 1'b0;
  logic [7:0]  branch_target = '0;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: an outstanding request (possibly marked for discard), a held instruction,
  // and the one quiet cycle after reset release.
  bit          m_first;
  bit          m_req;
  bit          m_disc;
  bit          m_have;
  logic [7:0]  m_addr;
  logic [15:0] m_instr;

  fetch_ctrl #(.AW(8), .IW(16)) dut (
    .clock(clock), .reset(reset), .pcout(pc), .pcin(pcin), .incr(incr), .load(load),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_valid(branch_valid), .branch_target(branch_target)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_first = 1'b1;
    m_req   = 1'b0;
    m_disc  = 1'b0;
    m_have  = 1'b0;
    m_addr  = '0;
    m_instr = '0;
  endtask

  // One clock cycle: drive inputs, compare at negedge, advance model at posedge.
  task automatic cyc(input bit ack, input logic [15:0] rd, input bit rdy, input bit bv, input logic [7:0] bt);
    bit          e_incr;
    bit          n_req, n_disc, n_have;
    logic [7:0]  n_addr, n_pc;
    logic [15:0] n_instr;
    mem_ack = ack; mem_rdata = rd; instr_ready = rdy; branch_valid = bv; branch_target = bt;
    @(negedge clock);
    e_incr = m_req && ack && !m_disc && !bv;
    chk("incr", 32'(incr), 32'(e_incr));
    chk("load", 32'(load), 32'(bv));
    chk("pcin", 32'(pcin), 32'(bt));
    chk("mem_req", 32'(mem_req), 32'(m_req));
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("instr", 32'(instr), 32'(m_instr));
    chk("instr_valid", 32'(instr_valid), 32'(m_have));
    $display("cyc t=%0t ack=%0d bv=%0d rdy=%0d req=%0d addr=%02h valid=%0d instr=%04h incr=%0d load=%0d",
             $time, ack, bv, rdy, mem_req, mem_addr, instr_valid, instr, incr, load);
    n_req = m_req; n_disc = m_disc; n_have = m_have; n_addr = m_addr; n_instr = m_instr;
    if (m_first) begin
      // quiet cycle after reset
    end else if (m_req) begin
      if (ack) begin
        n_req = 1'b0;
        n_disc = 1'b0;
        if (!m_disc && !bv) begin
          n_have = 1'b1;
          n_instr = rd;
        end
      end else if (bv) begin
        n_disc = 1'b1;
      end
    end else if (m_have) begin
      if (bv || rdy) n_have = 1'b0;
    end else if (!bv) begin
      n_req = 1'b1;
      n_addr = pc;
    end
    n_pc = bv ? bt : (e_incr ? pc + 8'd1 : pc);
    @(posedge clock);
    #1;
    m_first = 1'b0;
    m_req = n_req; m_disc = n_disc; m_have = n_have; m_addr = n_addr; m_instr = n_instr;
    pc = n_pc;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_instr"}, 32'(instr), 32'd0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_incr"}, 32'(incr), 32'd0);
    chk({tag, "_load"}, 32'(load), 32'd0);
  endtask

  task automatic mid_reset();
    #2;
    branch_valid = 1'b1;
    mem_ack = 1'b1;
    reset = 1'b0;
    #1;
    reset_checks("midrst");
    @(posedge clock);
    #1;
    branch_valid = 1'b0;
    mem_ack = 1'b0;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    bit a;
    branch_valid = 1'b1;
    mem_ack = 1'b1;
    #12;
    reset_checks("rst");
    branch_valid = 1'b0;
    mem_ack = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();

    // Basic fetch at 0x03 with zero-wait ack
    cyc(0, 16'h0, 1, 0, 8'h0);
    cyc(0, 16'h0, 1, 0, 8'h0);
    chk("t1_addr", 32'(mem_addr), 32'h03);
    chk("t1_req", 32'(mem_req), 32'd1);
    cyc(1, 16'hA5A5, 1, 0, 8'h0);
    chk("t1_instr", 32'(instr), 32'hA5A5);
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_req_drop", 32'(mem_req), 32'd0);
    cyc(0, 16'h0, 1, 0, 8'h0);
    chk("t1_valid_clr", 32'(instr_valid), 32'd0);
    cyc(0, 16'h0, 1, 0, 8'h0);
    chk("t1_next_addr", 32'(mem_addr), 32'h04);

    // Decode stalls four cycles in HOLD
    cyc(1, 16'h1234, 0, 0, 8'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 16'h0, 0, 0, 8'h0);
      chk("t2_valid", 32'(instr_valid), 32'd1);
      chk("t2_instr", 32'(instr), 32'h1234);
      chk("t2_req", 32'(mem_req), 32'd0);
    end
    cyc(0, 16'h0, 1, 0, 8'h0);
    cyc(0, 16'h0, 1, 0, 8'h0);
    chk("t2_next_addr", 32'(mem_addr), 32'h05);

    // Branch during WAIT, ack two cycles later is discarded
    cyc(0, 16'h0, 1, 1, 8'h40);
    chk("t3_req_held", 32'(mem_req), 32'd1);
    cyc(0, 16'h0, 1, 0, 8'h0);
    cyc(1, 16'hDEAD, 1, 0, 8'h0);
    chk("t3_valid", 32'(instr_valid), 32'd0);
    chk("t3_instr", 32'(instr), 32'h1234);
    cyc(0, 16'h0, 1, 0, 8'h0);
    chk("t3_addr", 32'(mem_addr), 32'h40);

    // Branch coincident with ack
    cyc(1, 16'hBEEF, 1, 1, 8'h80);
    chk("t4_valid", 32'(instr_valid), 32'd0);
    cyc(0, 16'h0, 1, 0, 8'h0);
    chk("t4_addr", 32'(mem_addr), 32'h80);

    // Branch to 0xFF from HOLD, then wrap to 0x00
    cyc(1, 16'h5555, 0, 0, 8'h0);
    cyc(0, 16'h0, 0, 1, 8'hFF);
    chk("t5_drop", 32'(instr_valid), 32'd0);
    cyc(0, 16'h0, 1, 0, 8'h0);
    chk("t5_addr_ff", 32'(mem_addr), 32'hFF);
    cyc(1, 16'h7777, 1, 0, 8'h0);
    cyc(0, 16'h0, 1, 0, 8'h0);
    cyc(0, 16'h0, 1, 0, 8'h0);
    chk("t5_wrap", 32'(mem_addr), 32'h00);

    // Randomized traffic with occasional mid-operation reset
    for (int i = 0; i < 3000; i++) begin
      if (i % 600 == 599) mid_reset();
      a = m_req ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 5);
      cyc(a, 16'($urandom), $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 8, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
